// File: rtl/boot_pkg.sv
// Shared types and constants for the SPI-flash boot loader.
package boot_pkg;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, WRITE, DONE} boot_state_t;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam int         CMD_BITS     = 8;
  localparam int         ADDR_BITS    = 24;
  localparam int         WORD_BITS    = 32;

  // The first flash byte of a word lands in bits [7:0].
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/boot_spi_shifter.sv
// SPI mode-0 master shifter: SCK divider, shared TX/RX shift register, bit counter.
module boot_spi_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [5:0]  nbits_i,
  input  logic [31:0] tx_data_i,
  input  logic        miso_i,
  output logic        sck_o,
  output logic        mosi_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rx_data_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]  div_q, div_d;
  logic        sck_q, sck_d;
  logic        busy_q, busy_d;
  logic        bit_q, bit_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  nbits_q, nbits_d;
  logic [31:0] sh_q, sh_d;
  logic        tick, fall;

  assign tick      = busy_q && (div_q == DIV_LAST);
  assign fall      = tick && sck_q;
  // done is combinational so a back-to-back start keeps the bit period seamless
  assign done_o    = fall && (cnt_q == nbits_q - 6'd1);
  assign sck_o     = sck_q;
  assign mosi_o    = busy_q & sh_q[31];
  assign busy_o    = busy_q;
  assign rx_data_o = {sh_q[30:0], bit_q};

  always_comb begin
    div_d   = div_q;
    sck_d   = sck_q;
    busy_d  = busy_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    nbits_d = nbits_q;
    sh_d    = sh_q;
    if (busy_q) begin
      div_d = tick ? 8'd0 : div_q + 8'd1;
      if (tick) sck_d = ~sck_q;
      if (tick && !sck_q) bit_d = miso_i;
      if (fall) begin
        sh_d  = {sh_q[30:0], bit_q};
        cnt_d = cnt_q + 6'd1;
      end
      if (done_o) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
    if (start_i) begin
      busy_d  = 1'b1;
      div_d   = '0;
      sck_d   = 1'b0;
      cnt_d   = '0;
      nbits_d = nbits_i;
      sh_d    = tx_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      sck_q   <= 1'b0;
      busy_q  <= 1'b0;
      bit_q   <= 1'b0;
      cnt_q   <= '0;
      nbits_q <= '0;
      sh_q    <= '0;
    end else begin
      div_q   <= div_d;
      sck_q   <= sck_d;
      busy_q  <= busy_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      nbits_q <= nbits_d;
      sh_q    <= sh_d;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Copies BOOT_WORDS words from SPI flash into memory, then releases the core from reset.
module boot_loader
  import boot_pkg::*;
#(
  parameter int          CLK_DIV    = 4,
  parameter int          BOOT_WORDS = 1024,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int          MEM_AW     = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              spi_sck,
  output logic              spi_ss,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              boot_sequence_done
);

  // 17 bits so BOOT_WORDS = 65536 never wraps
  localparam logic [16:0] LAST_WORD = 17'(BOOT_WORDS - 1);

  boot_state_t       state_q, state_d;
  logic [16:0]       cnt_q, cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        sh_start, sh_busy, sh_done;
  logic [5:0]  sh_nbits;
  logic [31:0] sh_tx, sh_rx;

  boot_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .start_i   (sh_start),
    .nbits_i   (sh_nbits),
    .tx_data_i (sh_tx),
    .miso_i    (spi_miso),
    .sck_o     (spi_sck),
    .mosi_o    (spi_mosi),
    .busy_o    (sh_busy),
    .done_o    (sh_done),
    .rx_data_o (sh_rx)
  );

  assign spi_ss             = (state_q == IDLE) || (state_q == DONE);
  assign mem_valid          = (state_q == WRITE);
  assign mem_addr           = addr_q;
  assign mem_wdata          = wdata_q;
  assign core_rst           = (state_q != DONE);
  assign boot_sequence_done = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sh_start = 1'b0;
    sh_nbits = 6'(WORD_BITS);
    sh_tx    = '0;
    unique case (state_q)
      IDLE: if (!sh_busy) begin
        state_d  = CMD;
        sh_start = 1'b1;
        sh_nbits = 6'(CMD_BITS);
        sh_tx    = {SPI_CMD_READ, 24'h0};
      end
      CMD: if (sh_done) begin
        state_d  = ADDR;
        sh_start = 1'b1;
        sh_nbits = 6'(ADDR_BITS);
        sh_tx    = {FLASH_BASE, 8'h0};
      end
      ADDR: if (sh_done) begin
        state_d  = DATA;
        sh_start = 1'b1;
      end
      DATA: if (sh_done) begin
        state_d = WRITE;
        wdata_d = byte_swap(sh_rx);
      end
      WRITE: if (mem_ready) begin
        addr_d = addr_q + MEM_AW'(1);
        if (cnt_q == LAST_WORD) begin
          state_d = DONE;
        end else begin
          cnt_d    = cnt_q + 17'd1;
          state_d  = DATA;
          sh_start = 1'b1;
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
